// File: rtl/timer_clock_select.sv
// timer_clock_select: count-enable strobe generator for the 8-bit timer.
// Selects an internal prescaler tap or a synchronized external pin edge and
// emits a registered one-cycle CountPulse. Fully synchronous to Clock.
// Optional build macro: TIMER_NOISE_FILTER_EN adds a 3-sample stability
// filter after the external-pin synchronizer.
module timer_clock_select #(
  parameter int unsigned PRESCALE_WIDTH = 10,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      TimerEnable,
  input  logic [2:0]                ClockSelect,
  input  logic [1:0]                ClockEdge,
  input  logic                      ExtClockPin,
  output logic                      CountPulse,
  output logic [PRESCALE_WIDTH-1:0] PrescalerCount,
  output logic                      ExtClockSync
);

  typedef enum logic [2:0] {
    SEL_DIV1    = 3'b000,
    SEL_DIV2    = 3'b001,
    SEL_DIV8    = 3'b010,
    SEL_DIV32   = 3'b011,
    SEL_DIV64   = 3'b100,
    SEL_DIV1024 = 3'b101,
    SEL_EXT     = 3'b110,
    SEL_RSVD    = 3'b111
  } sel_e;

  sel_e                      sel_q, sel_d;
  logic [1:0]                edge_q, edge_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [SYNC_STAGES-1:0]    sync_q, sync_d;
  logic                      hist_q, hist_d;
  logic                      pulse_q, pulse_d;

  logic                      sync_lvl;
  logic                      ext_lvl;
  logic                      cfg_change;
  logic                      internal_sel;
  logic [PRESCALE_WIDTH-1:0] tap_mask;
  logic                      ext_rise, ext_fall;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef TIMER_NOISE_FILTER_EN
  logic f1_q, f1_d, f2_q, f2_d;

  // Filtered level moves only when the last three synchronized samples agree;
  // hist_q doubles as the filtered level so the edge is seen one cycle sooner.
  always_comb begin
    f1_d    = sync_lvl;
    f2_d    = f1_q;
    ext_lvl = hist_q;
    if ((sync_lvl == f1_q) && (sync_lvl == f2_q)) begin
      ext_lvl = sync_lvl;
    end
  end

  // Filter sample history.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      f1_q <= 1'b0;
      f2_q <= 1'b0;
    end else begin
      f1_q <= f1_d;
      f2_q <= f2_d;
    end
  end

  assign ExtClockSync = hist_q;
`else
  assign ext_lvl      = sync_lvl;
  assign ExtClockSync = sync_lvl;
`endif

  // Tap selection, config-change detect, prescaler and strobe next-state.
  always_comb begin
    sel_d        = sel_e'(ClockSelect);
    edge_d       = ClockEdge;
    sync_d       = {sync_q[SYNC_STAGES-2:0], ExtClockPin};
    hist_d       = ext_lvl;
    presc_d      = presc_q;
    pulse_d      = 1'b0;
    tap_mask     = '0;
    internal_sel = 1'b1;
    cfg_change   = (sel_d != sel_q) || (edge_d != edge_q);
    ext_rise     = ext_lvl & ~hist_q;
    ext_fall     = ~ext_lvl & hist_q;

    case (sel_d)
      SEL_DIV1:    tap_mask = '0;
      SEL_DIV2:    tap_mask = PRESCALE_WIDTH'(1);
      SEL_DIV8:    tap_mask = PRESCALE_WIDTH'(7);
      SEL_DIV32:   tap_mask = PRESCALE_WIDTH'(31);
      SEL_DIV64:   tap_mask = PRESCALE_WIDTH'(63);
      SEL_DIV1024: tap_mask = PRESCALE_WIDTH'(1023);
      default:     internal_sel = 1'b0;
    endcase

    if (cfg_change || !internal_sel) begin
      presc_d = '0;
    end else if (TimerEnable) begin
      presc_d = presc_q + PRESCALE_WIDTH'(1);
    end

    // A config change suppresses the strobe; history still reloads from the
    // current level so nothing stale fires afterwards.
    if (TimerEnable && !cfg_change) begin
      if (internal_sel) begin
        pulse_d = ((presc_q & tap_mask) == tap_mask);
      end else if (sel_d == SEL_EXT) begin
        pulse_d = (edge_d[0] & ext_rise) | (edge_d[1] & ext_fall);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sel_q   <= SEL_DIV1;
      edge_q  <= '0;
      presc_q <= '0;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      edge_q  <= edge_d;
      presc_q <= presc_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign CountPulse     = pulse_q;
  assign PrescalerCount = presc_q;

endmodule

// File: doc/timer_clock_select.md
Name: timer_clock_select

Overview:
- Front end of the 8-bit timer: produces the single-cycle count-enable strobe that advances the timer counter.
- Sources: an internal prescaler divided from the system clock, or an external clock pin sampled synchronously with programmable edge selection.
- Fully synchronous to the system clock. Drives the counter's enable input; no derived or gated clocks.

Parameters:
- PRESCALE_WIDTH, 10, prescaler counter width; must be >= 10 to support /1024.
- SYNC_STAGES, 2, flip-flop stages in the external-pin synchronizer (min 2).

Ports:
- Clock  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- TimerEnable  in  1  1 = prescaler and strobe generation run; 0 = frozen, no strobes.
- ClockSelect  in  3  000 /1, 001 /2, 010 /8, 011 /32, 100 /64, 101 /1024, 110 external pin, 111 reserved (no strobes).
- ClockEdge  in  2  external mode only: 00 prohibited, 01 rising, 10 falling, 11 both edges.
- ExtClockPin  in  1  asynchronous external count source.
- CountPulse  out  1  one-cycle count-enable strobe to the counter.
- PrescalerCount  out  PRESCALE_WIDTH  current prescaler value (debug/readback).
- ExtClockSync  out  1  synchronized (and filtered, if enabled) external level.

Behaviour:
- Reset values: CountPulse=0, PrescalerCount=0, ExtClockSync=0, all synchronizer stages and edge history = 0, config shadow = 000/00.
- Prescaler:
  - Increments by 1 each cycle while TimerEnable=1 and ClockSelect is in 000-101.
  - Wraps from 2^PRESCALE_WIDTH-1 to 0.
  - Holds when TimerEnable=0.
  - Held at 0 when ClockSelect is 110 or 111.
- Internal modes, divide N (1,2,8,32,64,1024):
  - CountPulse=1 in the cycle after the prescaler's low log2(N) bits equal all ones; otherwise 0.
  - /1: CountPulse=1 every enabled cycle, starting one cycle after TimerEnable rises.
  - Steady-state strobe period is exactly N cycles.
  - ClockEdge is ignored.
- External mode (110):
  - ExtClockPin passes through the SYNC_STAGES synchronizer.
  - Edge detect compares the synchronized level with a one-cycle history register.
  - Rising/falling/both qualification follows ClockEdge.
  - CountPulse is registered: pin transition -> strobe after SYNC_STAGES+1 cycles.
  - ClockEdge=00: no strobes.
  - Synchronizer and edge history keep sampling while TimerEnable=0, so no stale edge fires on re-enable. Edges seen while disabled are discarded.
- Reserved select (111): no strobes, prescaler held at 0.
- Configuration change:
  - Any change of ClockSelect or ClockEdge (compared with the shadow register) clears the prescaler to 0.
  - Edge history is reloaded from the current synchronized level, so no edge is detected in that cycle.
  - CountPulse is forced to 0 in the following cycle.
  - Shadow updates every cycle.
- TimerEnable falling: CountPulse=0 from the next cycle. No partial-period strobe; the prescaler value is retained.
- Reset mid-operation: all state returns to reset values on the next edge; a pending strobe is dropped.
- CountPulse is never high for two consecutive cycles, except in /1 mode and in external both-edges mode with a pin toggling every cycle.

Optional Feature:
- Macro: TIMER_NOISE_FILTER_EN.
- Defined:
  - A 3-sample majority-stable filter follows the synchronizer.
  - The filtered level changes only after the synchronized level holds a new value for 3 consecutive cycles.
  - Pulses shorter than 3 cycles are rejected.
  - External latency becomes SYNC_STAGES+3 cycles.
  - ExtClockSync reports the filtered level.
- Undefined: no filter; ExtClockSync equals the last synchronizer stage; latency SYNC_STAGES+1.

Test Plan:
- Reset, TimerEnable=1, ClockSelect=010 (/8), run 64 cycles -> exactly 8 CountPulse strobes, 8 cycles apart. PrescalerCount reads 64 mod 1024 at the end.
- ClockSelect=101 (/1024), run 2048 cycles -> 2 strobes spaced 1024 cycles. Toggling TimerEnable to 0 for 100 cycles mid-run delays the next strobe by exactly 100 cycles.
- ClockSelect=110, ClockEdge=01, toggle ExtClockPin with period 10 cycles, 5 pulses -> 5 strobes, each 3 cycles (SYNC_STAGES=2) after the rising pin edge. ClockEdge=11 -> 10 strobes. ClockEdge=00 -> 0 strobes.
- Switch ClockSelect from 010 to 110 while PrescalerCount=5 -> PrescalerCount=0 next cycle, no CountPulse in the cycle after the change, even if ExtClockPin is high.
- Assert Reset while in /1 mode with CountPulse=1 -> CountPulse=0, PrescalerCount=0, ExtClockSync=0 on the next cycle.
- With TIMER_NOISE_FILTER_EN, external rising mode: 2-cycle-wide high glitch -> no strobe; 4-cycle-wide pulse -> 1 strobe at SYNC_STAGES+3 cycles after the rising edge.
